// File: rtl/bk_prefix_adder_pipe.sv
// bk_prefix_adder_pipe
//   Pipelined Brent-Kung parallel-prefix adder/subtractor with valid/ready
//   handshakes and a pass-through user tag.
//
//   The prefix network has 2*log2(WIDTH)-1 levels: log2(WIDTH) up-sweep levels
//   followed by log2(WIDTH)-1 down-sweep levels. Level 0 is the operand
//   preprocessing (invert B for subtract, fold the carry-in into G[0]).
//   PIPE_STAGES-1 internal register boundaries are spread evenly across the
//   levels, and the last register sits at the outputs.
//
//   Ports
//     clk, rst_n          clock, asynchronous active-low reset
//     in_valid/in_ready   input handshake (in_ready = out_ready || !out_valid)
//     in_op1, in_op2      operands A and B
//     in_cin              carry-in (ignored when in_sub=1)
//     in_sub              1 = A-B
//     in_tag              user tag, returned with the result
//     out_valid/out_ready output handshake
//     out_res             sum/difference modulo 2^WIDTH
//     out_cout            carry out of the MSB (subtract: 1 = no borrow)
//     out_ovf             two's-complement signed overflow
//     out_tag             tag of the result on out_res
module bk_prefix_adder_pipe #(
    parameter int WIDTH       = 32,
    parameter int PIPE_STAGES = 2,
    parameter int TAG_W       = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_op1,
    input  logic [WIDTH-1:0] in_op2,
    input  logic             in_cin,
    input  logic             in_sub,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_res,
    output logic             out_cout,
    output logic             out_ovf,
    output logic [TAG_W-1:0] out_tag
);

    localparam int LOG_W = $clog2(WIDTH);
    localparam int LVLS  = 2 * LOG_W - 1;

    // State carried between prefix levels. p0 is the bitwise propagate from
    // level 0, needed for the final sum after p has been merged into groups.
    typedef struct packed {
        logic             vld;
        logic [WIDTH-1:0] g;
        logic [WIDTH-1:0] p;
        logic [WIDTH-1:0] p0;
        logic             c0;
        logic             am;
        logic             bm;
        logic [TAG_W-1:0] tag;
    } lvl_t;

    // True when a register boundary sits right after level k.
    function automatic logic is_bnd(input int k);
        logic r;
        r = 1'b0;
        for (int j = 1; j < PIPE_STAGES; j++)
            if ((j * LVLS) / PIPE_STAGES == k) r = 1'b1;
        return r;
    endfunction

    // Distance from a black cell to the lower group it merges with.
    function automatic int span(input int k);
        if (k <= LOG_W) return 1 << (k - 1);
        else            return 1 << (LVLS - k);
    endfunction

    // Bit positions holding a black cell on level k. Up-sweep cells sit at
    // i = m*2^k - 1; down-sweep cells fill in the midpoints left behind.
    function automatic logic [WIDTH-1:0] cell_mask(input int k);
        logic [WIDTH-1:0] m;
        int s;
        m = '0;
        s = span(k);
        for (int i = 0; i < WIDTH; i++) begin
            if (k <= LOG_W) begin
                if (((i + 1) % (2 * s)) == 0) m = m | (WIDTH'(1) << i);
            end else begin
                if ((((i + 1) % (2 * s)) == s) && (i >= 2 * s)) m = m | (WIDTH'(1) << i);
            end
        end
        return m;
    endfunction

    logic             adv;
    logic [WIDTH-1:0] bp;
    logic             c0;
    lvl_t             cur [0:LVLS];
    lvl_t             stg [0:LVLS-1];
    lvl_t             src;
    logic [WIDTH-1:0] msk;
    logic [WIDTH-1:0] res;

    // Every stage shifts together; a full, stalled pipe holds bubbles as well.
    assign adv      = out_ready || !out_valid;
    assign in_ready = adv;

    always_comb begin
        for (int k = 0; k <= LVLS; k++) cur[k] = '0;
        src = '0;
        msk = '0;

        bp = in_sub ? ~in_op2 : in_op2;
        c0 = in_sub | in_cin;

        cur[0].vld  = in_valid;
        cur[0].p    = in_op1 ^ bp;
        cur[0].g    = in_op1 & bp;
        // Carry-in enters as generate of bit 0: majority(A0, B'0, c0).
        cur[0].g[0] = (in_op1[0] & bp[0]) | (in_op1[0] & c0) | (bp[0] & c0);
        cur[0].p0   = in_op1 ^ bp;
        cur[0].c0   = c0;
        cur[0].am   = in_op1[WIDTH-1];
        cur[0].bm   = bp[WIDTH-1];
        cur[0].tag  = in_tag;

        for (int k = 1; k <= LVLS; k++) begin
            src    = is_bnd(k - 1) ? stg[k-1] : cur[k-1];
            msk    = cell_mask(k);
            cur[k] = src;
            cur[k].g = src.g | (msk & src.p & (src.g << span(k)));
            cur[k].p = (src.p & ~msk) | (msk & src.p & (src.p << span(k)));
        end

        // After the last level g[i] is the carry out of bit i.
        res = cur[LVLS].p0 ^ {cur[LVLS].g[WIDTH-2:0], cur[LVLS].c0};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < LVLS; k++) stg[k] <= '0;
        end else if (adv) begin
            for (int k = 0; k < LVLS; k++)
                if (is_bnd(k)) stg[k] <= cur[k];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_res   <= '0;
            out_cout  <= 1'b0;
            out_ovf   <= 1'b0;
            out_tag   <= '0;
        end else if (adv) begin
            out_valid <= cur[LVLS].vld;
            out_res   <= res;
            out_cout  <= cur[LVLS].g[WIDTH-1];
            out_ovf   <= (cur[LVLS].am == cur[LVLS].bm) && (res[WIDTH-1] != cur[LVLS].am);
            out_tag   <= cur[LVLS].tag;
        end
    end

endmodule

// File: tb/tb_bk_prefix_adder_pipe.sv
module tb_bk_prefix_adder_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, in_cin, in_sub;
    logic [31:0] in_op1, in_op2;
    logic [3:0]  in_tag;
    logic        out_valid, out_ready, out_cout, out_ovf;
    logic [31:0] out_res;
    logic [3:0]  out_tag;

    always #5 clk = ~clk;

    bk_prefix_adder_pipe #(.WIDTH(32), .PIPE_STAGES(2), .TAG_W(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_op1(in_op1), .in_op2(in_op2), .in_cin(in_cin), .in_sub(in_sub), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_res(out_res), .out_cout(out_cout), .out_ovf(out_ovf), .out_tag(out_tag)
    );

    typedef struct {
        logic [31:0] res;
        logic        cout;
        logic        ovf;
        logic [3:0]  tag;
    } exp_t;

    exp_t sb[$];
    int   nvec = 0;
    int   nerr = 0;
    logic stall_done;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
        nvec++;
        if (act !== want) begin
            nerr++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, want, $time);
        end
    endtask

    function automatic exp_t mk(input logic [31:0] r, input logic c, input logic o, input logic [3:0] t);
        exp_t e;
        e.res = r; e.cout = c; e.ovf = o; e.tag = t;
        return e;
    endfunction

    // Reference arithmetic for generated streams.
    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                   input logic cin, input logic sub, input logic [3:0] t);
        logic [31:0] bb;
        logic [32:0] s;
        bb = sub ? ~b : b;
        s  = {1'b0, a} + {1'b0, bb} + {32'd0, (sub | cin)};
        return mk(s[31:0], s[32], (a[31] == bb[31]) && (s[31] != a[31]), t);
    endfunction

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic cin,
                        input logic sub, input logic [3:0] t, input exp_t e);
        in_valid = 1'b1; in_op1 = a; in_op2 = b; in_cin = cin; in_sub = sub; in_tag = t;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (in_ready) begin
                sb.push_back(e);
                @(posedge clk); #1;
                in_valid = 1'b0;
                return;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        chk("accept_timeout", 64'd0, 64'd1);
    endtask

    // Idle pipe, out_ready=1: result must appear exactly two edges after acceptance.
    task automatic send_lat(input logic [31:0] a, input logic [31:0] b, input logic cin,
                            input logic sub, input logic [3:0] t, input exp_t e);
        send(a, b, cin, sub, t, e);
        chk("latency_early", {63'd0, out_valid}, 64'd0);
        @(posedge clk); #1;
        chk("latency", {59'd0, out_valid, out_tag}, {59'd0, 1'b1, t});
    endtask

    task automatic drain();
        for (int n = 0; n < 300 && sb.size() != 0; n++) @(posedge clk);
        chk("drain", 64'(sb.size()), 64'd0);
        @(posedge clk); #1;
    endtask

    // Monitor: pops on every output transfer, and checks stall behaviour.
    logic [37:0] held;
    logic        held_v = 1'b0;
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid && !out_ready) begin
                chk("in_ready_stall", {63'd0, in_ready}, 64'd0);
                if (held_v) chk("hold", {26'd0, out_res, out_cout, out_ovf, out_tag}, {26'd0, held});
                held   = {out_res, out_cout, out_ovf, out_tag};
                held_v = 1'b1;
            end else begin
                held_v = 1'b0;
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_out", {26'd0, out_res, out_cout, out_ovf, out_tag}, 64'd0 - 1);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("result", {26'd0, out_res, out_cout, out_ovf, out_tag},
                        {26'd0, e.res, e.cout, e.ovf, e.tag});
                end
            end
        end else begin
            held_v = 1'b0;
        end
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_op1 = '0; in_op2 = '0;
        in_cin = 1'b0; in_sub = 1'b0; in_tag = '0; out_ready = 1'b1;
        stall_done = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_out", {26'd0, out_valid, out_res, out_cout, out_ovf, out_tag}, 64'd0);
        chk("reset_in_ready", {63'd0, in_ready}, 64'd1);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed arithmetic
        send_lat(32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 4'd3, mk(32'h00000000, 1'b1, 1'b0, 4'd3));
        send(32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 4'd4, mk(32'h80000000, 1'b0, 1'b1, 4'd4));
        send(32'h12345678, 32'h0FEDCBA9, 1'b1, 1'b0, 4'd5, mk(32'h22222222, 1'b0, 1'b0, 4'd5));
        send(32'h00000005, 32'h00000007, 1'b0, 1'b1, 4'd6, mk(32'hFFFFFFFE, 1'b0, 1'b0, 4'd6));
        send(32'h00000005, 32'h00000007, 1'b1, 1'b1, 4'd7, mk(32'hFFFFFFFE, 1'b0, 1'b0, 4'd7));
        send(32'h80000000, 32'h00000001, 1'b0, 1'b1, 4'd8, mk(32'h7FFFFFFF, 1'b1, 1'b1, 4'd8));
        send(32'h80000000, 32'h80000000, 1'b0, 1'b0, 4'd9, mk(32'h00000000, 1'b1, 1'b1, 4'd9));
        send(32'hAAAAAAAA, 32'h55555555, 1'b1, 1'b0, 4'hF, mk(32'h00000000, 1'b1, 1'b0, 4'hF));
        drain();

        // Back-to-back stream with a 3-cycle output stall
        fork
            begin
                for (int i = 0; i < 8; i++)
                    send(32'h11111111 * i, 32'(i) << 28, 1'b0, 1'b0, 4'(i),
                         model(32'h11111111 * i, 32'(i) << 28, 1'b0, 1'b0, 4'(i)));
            end
            begin
                repeat (3) @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (3) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain();

        // Asynchronous reset mid-cycle with two operations in flight
        out_ready = 1'b0;
        send(32'h00000001, 32'h00000001, 1'b0, 1'b0, 4'd1, mk(32'h2, 1'b0, 1'b0, 4'd1));
        send(32'h00000002, 32'h00000002, 1'b0, 1'b0, 4'd2, mk(32'h4, 1'b0, 1'b0, 4'd2));
        chk("full_in_ready", {63'd0, in_ready}, 64'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset_out", {26'd0, out_valid, out_res, out_cout, out_ovf, out_tag}, 64'd0);
        chk("async_reset_in_ready", {63'd0, in_ready}, 64'd1);
        sb.delete();
        @(posedge clk); #1;
        rst_n = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        send_lat(32'h00000010, 32'h00000003, 1'b0, 1'b1, 4'hA, mk(32'h0000000D, 1'b1, 1'b0, 4'hA));
        drain();
        repeat (5) @(posedge clk);
        #1;

        // Random operands with random output stalls
        fork
            begin
                for (int i = 0; i < 300; i++) begin
                    logic [31:0] a, b;
                    logic        ci, su;
                    a  = $urandom; b = $urandom;
                    ci = 1'($urandom_range(0, 1)); su = 1'($urandom_range(0, 1));
                    send(a, b, ci, su, 4'(i), model(a, b, ci, su, 4'(i)));
                end
                stall_done = 1'b1;
            end
            begin
                while (!stall_done) begin
                    @(posedge clk); #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
                out_ready = 1'b1;
            end
        join
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
